// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits return data combinationally; read misses fill a whole line from
// memory; every store is written through to memory while the core stalls.
module dcache_controller #(
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          MemRead,
  input  logic                          MemWrite,
  input  logic [31:0]                   addr,
  input  logic [31:0]                   wr_data,
  output logic [31:0]                   rd_data,
  output logic                          stall,
  output logic                          mem_rd_req,
  output logic                          mem_wr_req,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic [32*(2**OFFSET_W)-1:0]   mem_rdata,
  input  logic                          mem_ready
);

  localparam int LINES   = 2 ** INDEX_W;
  localparam int WORDS   = 2 ** OFFSET_W;
  localparam int IDX_LSB = OFFSET_W + 2;
  localparam int TAG_LSB = INDEX_W + OFFSET_W + 2;
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << IDX_LSB) - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [LINES-1:0]         r_valid;
  logic [TAG_W-1:0]         r_tag  [LINES];
  logic [WORDS-1:0][31:0]   r_data [LINES];
  logic [31:0]              r_addr;
  logic [31:0]              r_wdata;

  // Fields of the incoming core address
  logic [OFFSET_W-1:0]      w_offset;
  logic [INDEX_W-1:0]       w_index;
  logic [TAG_W-1:0]         w_tag;
  logic                     w_hit;
  // Fields of the registered transaction address
  logic [OFFSET_W-1:0]      w_r_offset;
  logic [INDEX_W-1:0]       w_r_index;
  logic [TAG_W-1:0]         w_r_tag;
  logic                     w_r_hit;

  logic                     w_stall;
  logic [31:0]              w_rd_data;
  logic                     w_fill_done;
  logic                     w_write_done;

  assign w_offset   = addr[IDX_LSB-1:2];
  assign w_index    = addr[TAG_LSB-1:IDX_LSB];
  assign w_tag      = addr[31:TAG_LSB];
  assign w_hit      = r_valid[w_index] & (r_tag[w_index] == w_tag);

  assign w_r_offset = r_addr[IDX_LSB-1:2];
  assign w_r_index  = r_addr[TAG_LSB-1:IDX_LSB];
  assign w_r_tag    = r_addr[31:TAG_LSB];
  assign w_r_hit    = r_valid[w_r_index] & (r_tag[w_r_index] == w_r_tag);

  // A reset edge abandons any transaction, so completions only count out of reset
  assign w_fill_done  = rst_n & (r_state == ST_FILL)  & mem_ready;
  assign w_write_done = rst_n & (r_state == ST_WRITE) & mem_ready;

  // Core-facing outputs are forced quiet while reset is held
  assign stall     = rst_n & w_stall;
  assign rd_data   = rst_n ? w_rd_data : 32'd0;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  // Next-state, stall, read data and memory request decode
  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b0;
    w_rd_data  = 32'd0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (MemWrite) begin
          w_stall = 1'b1;
          w_next  = ST_WRITE;
        end else if (MemRead) begin
          if (w_hit) begin
            w_rd_data = r_data[w_index][w_offset];
          end else begin
            w_stall = 1'b1;
            w_next  = ST_FILL;
          end
        end else begin
          w_rd_data = 32'd0;
        end
      end
      ST_FILL: begin
        mem_rd_req = 1'b1;
        w_stall    = 1'b1;
        if (mem_ready) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_FILL;
        end
      end
      ST_WRITE: begin
        mem_wr_req = 1'b1;
        w_stall    = ~mem_ready;
        if (mem_ready) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_WRITE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, valid bits and the registered transaction address/data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_valid <= '0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && MemWrite) begin
        r_addr  <= addr & WORD_MASK;
        r_wdata <= wr_data;
      end else if ((r_state == ST_IDLE) && MemRead && !w_hit) begin
        r_addr  <= addr & LINE_MASK;
      end
      if (w_fill_done) begin
        r_valid[w_r_index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays: line fill on read completion, word update on a write-through hit
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[w_r_index]  <= w_r_tag;
      r_data[w_r_index] <= mem_rdata;
    end else if (w_write_done && w_r_hit) begin
      r_data[w_r_index][w_r_offset] <= r_wdata;
    end
  end

endmodule
